alu_arbiter: RTL and testbench

- Sequences and shares the single combinational ALU between two requesters (port 0, port 1).
- Round-robin grant. Operands and opcode are registered into the ALU. Each op is held for an op-class-dependent number of cycles, then the result is captured and returned with a requester tag.
- Sits between the issuing units and the ALU instance; it is the only block that drives the ALU inputs.

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Operands and control are registered toward the ALU, each op is
// held for a class-dependent number of cycles, and the captured result is
// returned with the owning requester's id.
module alu_arbiter #(
   parameter int N        = 32,
   parameter int SLOW_LAT = 4,
   parameter int FAST_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [N-1:0] req_a0,
   input  logic [N-1:0] req_b0,
   input  logic [N-1:0] req_a1,
   input  logic [N-1:0] req_b1,
   input  logic [5:0]   req_op0,
   input  logic [5:0]   req_op1,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [5:0]   alu_ctrl,
   input  logic [N-1:0] alu_result,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_data,
   output logic         rsp_err,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   // Counter preload is L-1: the edge on which the counter reads zero is the
   // L-th edge after accept, which is where the result is captured.
   localparam logic [3:0] FAST_CNT = 4'(FAST_LAT - 1);
   localparam logic [3:0] SLOW_CNT = 4'(SLOW_LAT - 1);

   state_t         state_q;
   logic           rr_q;
   logic [3:0]     cnt_q;
   logic [N-1:0]   alu_a_q, alu_b_q, rsp_data_q;
   logic [5:0]     alu_ctrl_q;
   logic           rsp_valid_q, rsp_id_q, rsp_err_q;

   logic           accept_d, grant_d;
   logic [N-1:0]   sel_a_d, sel_b_d;
   logic [5:0]     sel_op_d;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         6'b000001, 6'b000010, 6'b000110, 6'b000111,
         6'b000100, 6'b000101: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic op_slow(input logic [5:0] op);
      return (op == 6'b000100) || (op == 6'b000101);
   endfunction

   // Grant selection: a lone requester wins, contention goes to the RR pointer.
   // req_ready is gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      grant_d   = (req_valid == 2'b11) ? rr_q : req_valid[1];
      accept_d  = rst_n && (state_q == IDLE) && (|req_valid);
      req_ready = accept_d ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
      sel_a_d   = grant_d ? req_a1  : req_a0;
      sel_b_d   = grant_d ? req_b1  : req_b0;
      sel_op_d  = grant_d ? req_op1 : req_op0;
   end

   // Sequencer: accept in IDLE, count down in EXEC, hold response in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         cnt_q       <= 4'd0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= 6'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  alu_a_q  <= sel_a_d;
                  alu_b_q  <= sel_b_d;
                  rsp_id_q <= grant_d;
                  rr_q     <= ~grant_d;
                  if (op_legal(sel_op_d)) begin
                     alu_ctrl_q <= sel_op_d;
                     cnt_q      <= op_slow(sel_op_d) ? SLOW_CNT : FAST_CNT;
                     state_q    <= EXEC;
                  end else begin
                     // Illegal code never reaches the ALU; respond at once.
                     alu_ctrl_q  <= 6'd0;
                     cnt_q       <= 4'd0;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
            end
            EXEC: begin
               if (cnt_q == 4'd0) begin
                  rsp_data_q  <= alu_result;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  alu_ctrl_q  <= 6'd0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ctrl  = alu_ctrl_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of arbitration, latency and data.
module tb_alu_arbiter;

   localparam int N        = 32;
   localparam int SLOW_LAT = 4;
   localparam int FAST_LAT = 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req_valid, req_ready;
   logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
   logic [5:0]   req_op0, req_op1;
   logic [N-1:0] alu_a, alu_b, alu_result, rsp_data;
   logic [5:0]   alu_ctrl;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

   int total = 0;
   int bad   = 0;
   bit rr_ptr = 1'b0;   // model: requester favoured on contention

   alu_arbiter #(.N(N), .SLOW_LAT(SLOW_LAT), .FAST_LAT(FAST_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_op0(req_op0), .req_op1(req_op1), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .alu_result(alu_result), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy));

   always #5 clk = ~clk;

   function automatic logic [N-1:0] alu_fn(input logic [5:0] op, input logic [N-1:0] a, b);
      case (op)
         6'b000001: return a + b;
         6'b000010: return a - b;
         6'b000110: return a & b;
         6'b000111: return a | b;
         6'b000100: return (b == '0) ? '1 : a / b;
         6'b000101: return a * b;
         default:   return '0;
      endcase
   endfunction

   // Behavioural stand-in for the shared ALU.
   always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'd1, 6'd2, 6'd6, 6'd7, 6'd4, 6'd5};
   endfunction

   function automatic int lat_of(input logic [5:0] op);
      if (!is_legal(op)) return 0;
      return (op == 6'd4 || op == 6'd5) ? SLOW_LAT : FAST_LAT;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One complete transaction: present, accept, wait for response, optionally
   // stall the response, handshake. With keep=1 the requests stay asserted.
   task automatic run_op(input logic [1:0] mask,
                         input logic [5:0] op0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input logic [5:0] op1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                         input int hold, input bit keep);
      bit           w;
      logic [5:0]   wop;
      logic [N-1:0] wa, wb, exp_data, sa, sb, sd;
      logic [5:0]   sc;
      int           n;
      bit           unstable;
      @(negedge clk);
      req_valid = mask; rsp_ready = 1'b0;
      req_op0 = op0; req_a0 = a0; req_b0 = b0;
      req_op1 = op1; req_a1 = a1; req_b1 = b1;
      #1;
      w   = (mask == 2'b11) ? rr_ptr : mask[1];
      wop = w ? op1 : op0;
      wa  = w ? a1 : a0;
      wb  = w ? b1 : b0;
      exp_data = is_legal(wop) ? alu_fn(wop, wa, wb) : '0;
      check("req_ready", req_ready, w ? 2'b10 : 2'b01);
      check("idle_ctrl", alu_ctrl, 0);
      check("idle_busy", busy, 0);
      @(posedge clk); #1;
      rr_ptr = ~w;
      if (!keep) req_valid = 2'b00;
      check("alu_a", alu_a, wa);
      check("alu_ctrl", alu_ctrl, is_legal(wop) ? wop : 6'd0);
      sa = alu_a; sb = alu_b; sc = alu_ctrl;
      n = 0; unstable = 0;
      while (!rsp_valid && n < 40) begin
         if (req_ready !== 2'b00 || busy !== 1'b1) unstable = 1;
         @(posedge clk); #1;
         n++;
         if (alu_a !== sa || alu_b !== sb || alu_ctrl !== sc) unstable = 1;
      end
      check("latency", n, lat_of(wop));
      check("exec_stable", unstable, 0);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_id", rsp_id, w);
      check("rsp_err", rsp_err, !is_legal(wop));
      sd = rsp_data; unstable = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_data !== sd || rsp_id !== w || req_ready !== 2'b00 ||
             busy !== 1'b1 || alu_ctrl !== sc) unstable = 1;
      end
      check("resp_hold", unstable, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_clear", rsp_valid, 0);
      check("post_busy", busy, 0);
      check("post_ctrl", alu_ctrl, 0);
      if (keep) check("reaccept", req_ready, (req_valid == 2'b11) ? (rr_ptr ? 2'b10 : 2'b01)
                                                                  : {req_valid[1], req_valid[0] & ~req_valid[1]});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [5:0] ops [7];
      bit         stale;
      ops = '{6'd1, 6'd2, 6'd6, 6'd7, 6'd4, 6'd5, 6'd3};
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ctrl", alu_ctrl, 0);
      @(negedge clk); rst_n = 1'b1;

      // Basic fast add on requester 0.
      run_op(2'b01, 6'd1, 5, 7, 6'd0, 0, 0, 0, 0);
      // Contention twice, then once more.
      run_op(2'b11, 6'd2, 10, 3, 6'd7, 32'hF0, 32'h0F, 0, 0);
      run_op(2'b11, 6'd2, 10, 3, 6'd7, 32'hF0, 32'h0F, 0, 0);
      run_op(2'b11, 6'd1, 1, 1, 6'd2, 9, 4, 0, 0);
      // Slow multiply on requester 1.
      run_op(2'b10, 6'd0, 0, 0, 6'd5, 6, 9, 0, 0);
      // Illegal control code.
      run_op(2'b01, 6'd3, 11, 22, 6'd0, 0, 0, 1, 0);
      // Stalled response with requester 0 still pending, then its re-accept.
      run_op(2'b01, 6'd1, 100, 23, 6'd0, 0, 0, 5, 1);
      run_op(2'b01, 6'd1, 100, 23, 6'd0, 0, 0, 0, 0);

      // Reset in the middle of a slow divide.
      @(negedge clk);
      req_valid = 2'b01; req_op0 = 6'd4; req_a0 = 100; req_b0 = 7;
      @(posedge clk); #1;
      req_valid = 2'b11;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("amid_busy", busy, 0);
      check("amid_alu_a", alu_a, 0);
      check("amid_alu_b", alu_b, 0);
      check("amid_ctrl", alu_ctrl, 0);
      check("amid_ready", req_ready, 0);
      check("amid_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
      @(negedge clk);
      req_valid = 2'b00; rst_n = 1'b1; rr_ptr = 1'b0;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1;
      end
      check("no_stale_rsp", stale, 0);
      run_op(2'b11, 6'd6, 32'hFF00, 32'h0FF0, 6'd1, 1, 2, 0, 0);

      // Random traffic.
      for (int t = 0; t < 40; t++) begin
         logic [1:0] m;
         m = 2'($urandom_range(1, 3));
         run_op(m, ops[$urandom_range(0, 6)], $urandom, $urandom_range(0, 300),
                   ops[$urandom_range(0, 6)], $urandom, $urandom_range(0, 300),
                   $urandom_range(0, 3), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
